// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with a registered divided clock and a
// period-start strobe. A new divisor is taken through a valid/ready handshake into a
// one-deep pending slot and applied only at the next period boundary, so clk_out never
// glitches.
// Optional feature macro: CLK_DIV_PROG_DUTY_PROG_EN adds a programmable high-time
// (cfg_high_i); without it the high-time is always floor(D/2).
module clk_div_prog #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEFAULT_DIV  = 10,
  parameter int unsigned DEFAULT_HIGH = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_div_i,
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
  input  logic [WIDTH-1:0] cfg_high_i,
`endif
  output logic             clk_out_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] cur_div_o
);

  localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(DEFAULT_DIV);
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
  localparam logic [WIDTH-1:0] ResetHigh = WIDTH'(DEFAULT_HIGH);
`else
  // DEFAULT_HIGH only matters when the duty cycle is programmable
  localparam logic [WIDTH-1:0] ResetHigh = WIDTH'((DEFAULT_DIV >> 1) + (DEFAULT_HIGH * 0));
`endif

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] cur_high_q, cur_high_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
  logic [WIDTH-1:0] pend_high_q, pend_high_d;
`endif

  logic             accept;
  logic             wrap;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH-1:0] app_div;
  logic [WIDTH-1:0] app_high;

  // Clamp the pending configuration into its legal range at the point of use
  always_comb begin
    app_div = (pend_div_q < WIDTH'(2)) ? WIDTH'(2) : pend_div_q;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
    if (pend_high_q == '0) begin
      app_high = WIDTH'(1);
    end else if (pend_high_q >= app_div) begin
      app_high = app_div - WIDTH'(1);
    end else begin
      app_high = pend_high_q;
    end
`else
    app_high = app_div >> 1;
`endif
  end

  // Next-state: counter, divided clock, strobe and the pending-config slot
  always_comb begin
    accept       = cfg_valid_i & ~pend_valid_q;
    wrap         = (cnt_q == cur_div_q - WIDTH'(1));
    // one extra bit so cnt+1 never wraps at the largest divisor
    cnt_inc      = {1'b0, cnt_q} + (WIDTH + 1)'(1);
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    cur_div_d    = cur_div_q;
    cur_high_d   = cur_high_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
    pend_high_d  = pend_high_q;
`endif
    if (en_i) begin
      if (wrap) begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
        if (pend_valid_q) begin
          cur_div_d    = app_div;
          cur_high_d   = app_high;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d     = cnt_q + WIDTH'(1);
        clk_out_d = (cnt_inc < {1'b0, cur_high_q});
      end
    end
    // accept only happens with the slot empty, so it never collides with an apply
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_div_d   = cfg_div_i;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
      pend_high_d  = cfg_high_i;
`endif
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q        <= ResetDiv - WIDTH'(1);
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      cur_div_q    <= ResetDiv;
      cur_high_q   <= ResetHigh;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
      pend_high_q  <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      cur_div_q    <= cur_div_d;
      cur_high_q   <= cur_high_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
`ifdef CLK_DIV_PROG_DUTY_PROG_EN
      pend_high_q  <= pend_high_d;
`endif
    end
  end

  assign cfg_ready_o = ~pend_valid_q;
  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign cur_div_o   = cur_div_q;

endmodule
